wb_register_file: RTL and testbench
===================================

// Module: wb_register_file
// PURPOSE
//  Write-back stage plus architectural register file for the 5-stage MIPS pipeline.
//  Consumes the MEM/WB pipeline register outputs and selects the write-back data.
//  Commits that data to the 32x32 register file and serves the two ID-stage read ports.
//  Read ports use write-through bypass, so no WB->ID hazard stall is needed.
// PARAMETERS
//  SP_INIT   32'h0000_07FC  reset value of $29 ($sp)
//  GP_INIT   32'h0000_1800  reset value of $28 ($gp)
//  CNT_W     32             width of the committed-write counter
// PORTS
//  clk                 in   1   rising-edge clock
//  reset               in   1   synchronous reset, active-low (0 = reset)
//  i_reg_write         in   1   write-back enable from MEM/WB
//  i_mem_to_reg        in   2   write-back source select from MEM/WB
//  i_write_register    in   5   destination register from MEM/WB
//  i_result            in   32  ALU result from MEM/WB
//  i_mem_read_data     in   32  load data from MEM/WB
//  i_pc_4              in   32  PC+4 from MEM/WB (jal/jalr link)
//  i_imm_ext_out       in   32  extended immediate from MEM/WB (lui)
//  i_read_register_1   in   5   ID read address, port 1 (rs)
//  i_read_register_2   in   5   ID read address, port 2 (rt)
//  o_read_data_1       out  32  read data, port 1
//  o_read_data_2       out  32  read data, port 2
//  o_write_data        out  32  selected write-back data (EX forwarding source)
//  o_write_commit      out  1   a non-$zero write commits at the next edge
//  o_commit_count      out  CNT_W  registered count of committed writes
// BEHAVIOUR
//  WB mux (combinational): i_mem_to_reg 00 = i_result, 01 = i_mem_read_data,
//   10 = i_pc_4, 11 = i_imm_ext_out. The result drives o_write_data.
//  o_write_commit = reset & i_reg_write & (i_write_register != 0).
//  Write: at posedge clk with o_write_commit = 1, regs[i_write_register] <= o_write_data.
//   Latency is 1 cycle to storage and 0 cycles to the read ports (bypass).
//  $zero: never stored. Reads of address 0 always return 0, including during a bypass.
//  Read port n (combinational):
//   - addr == 0 -> 0;
//   - else if o_write_commit and addr == i_write_register -> o_write_data (bypass);
//   - else regs[addr].
//   Both ports may hit the same address or the bypass simultaneously. Each resolves independently.
//  Reset (reset == 0 at posedge):
//   - regs[1..31] <= 0, except $28 <= GP_INIT and $29 <= SP_INIT;
//   - o_commit_count <= 0;
//   - any write presented in that cycle is dropped.
//   While reset is low, o_write_commit = 0 and the bypass is disabled.
//   Reads stay combinational on storage contents.
//  Reset mid-operation: no partial state. The first edge with reset high behaves as a normal write.
//  Counter: increments by 1 on each edge with o_write_commit = 1.
//   It wraps from 2^CNT_W-1 to 0 silently. Writes to $zero do not count.
//  No other state. Unknown i_mem_to_reg values cannot occur (the 2-bit select is fully decoded).
// TESTING
//  1 Reset low one edge, then read all 32 addresses -> $28 = 32'h1800, $29 = 32'h7FC, others 0.
//  2 reg_write=1, wr=5, sel=00, result=32'hDEAD_BEEF, rd1=5 in same cycle
//    -> o_read_data_1 = DEADBEEF before the edge; still DEADBEEF next cycle with reg_write=0.
//  3 Cycle sel 00/01/10/11 with result=1, mem=2, pc4=3, imm=4 to regs 8..11
//    -> regs hold 1, 2, 3, 4; o_commit_count = 4.
//  4 reg_write=1, wr=0, data=32'hFFFF_FFFF; rd1=rd2=0
//    -> both reads 0, o_write_commit = 0, count unchanged.
//  5 Write $7 = 32'h1234 with reset low at that edge
//    -> $7 stays 0, count 0; the same write after reset deasserts gives $7 = 32'h1234.
//  6 Preload o_commit_count = 2^32-1 (by force/backdoor) then commit one write -> count = 0.

Source files
------------

// File: rtl/wb_register_file.sv
// Write-back stage and 32x32 architectural register file for the 5-stage MIPS pipeline.
// Selects the write-back data, commits it, and serves two ID read ports with write-through bypass.
module wb_register_file #(
    parameter logic [31:0] SP_INIT = 32'h0000_07FC,
    parameter logic [31:0] GP_INIT = 32'h0000_1800,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_reg_write,
    input  logic [1:0]       i_mem_to_reg,
    input  logic [4:0]       i_write_register,
    input  logic [31:0]      i_result,
    input  logic [31:0]      i_mem_read_data,
    input  logic [31:0]      i_pc_4,
    input  logic [31:0]      i_imm_ext_out,
    input  logic [4:0]       i_read_register_1,
    input  logic [4:0]       i_read_register_2,
    output logic [31:0]      o_read_data_1,
    output logic [31:0]      o_read_data_2,
    output logic [31:0]      o_write_data,
    output logic             o_write_commit,
    output logic [CNT_W-1:0] o_commit_count
);

    logic [31:0]      regs_q [32];
    logic [31:0]      regs_d [32];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        o_write_data = i_result;
        case (i_mem_to_reg)
            2'b00: o_write_data = i_result;
            2'b01: o_write_data = i_mem_read_data;
            2'b10: o_write_data = i_pc_4;
            2'b11: o_write_data = i_imm_ext_out;
            default: o_write_data = i_result;
        endcase
    end

    // Gating with reset also disables the bypass while reset is held low.
    assign o_write_commit = reset & i_reg_write & (i_write_register != 5'd0);

    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        if (o_write_commit) begin
            regs_d[i_write_register] = o_write_data;
            count_d                  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            regs_q[28] <= GP_INIT;
            regs_q[29] <= SP_INIT;
            count_q    <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        o_read_data_1 = regs_q[i_read_register_1];
        if (i_read_register_1 == 5'd0) begin
            o_read_data_1 = 32'd0;
        end else if (o_write_commit && (i_read_register_1 == i_write_register)) begin
            o_read_data_1 = o_write_data;
        end
    end

    always_comb begin
        o_read_data_2 = regs_q[i_read_register_2];
        if (i_read_register_2 == 5'd0) begin
            o_read_data_2 = 32'd0;
        end else if (o_write_commit && (i_read_register_2 == i_write_register)) begin
            o_read_data_2 = o_write_data;
        end
    end

    assign o_commit_count = count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: a bench-side register model feeds a queue of
// expected read values that are popped and compared as the DUT outputs are sampled.
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  sel;
    logic [4:0]  wr;
    logic [31:0] res, mem, pc4, imm;
    logic [4:0]  rd1, rd2;
    logic [31:0] rdata1, rdata2, wdata;
    logic        commit;
    logic [31:0] cnt;
    logic [31:0] rdata1_s, rdata2_s, wdata_s;
    logic        commit_s;
    logic [2:0]  cnt_s;

    logic [31:0] model [32];
    logic [31:0] model_cnt;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int          n_cmp = 0;
    int          n_bad = 0;

    wb_register_file dut (
        .clk(clk), .reset(reset), .i_reg_write(we), .i_mem_to_reg(sel),
        .i_write_register(wr), .i_result(res), .i_mem_read_data(mem), .i_pc_4(pc4),
        .i_imm_ext_out(imm), .i_read_register_1(rd1), .i_read_register_2(rd2),
        .o_read_data_1(rdata1), .o_read_data_2(rdata2), .o_write_data(wdata),
        .o_write_commit(commit), .o_commit_count(cnt)
    );

    // Narrow-counter instance sharing all inputs, used to observe counter wrap.
    wb_register_file #(.CNT_W(3)) u_small (
        .clk(clk), .reset(reset), .i_reg_write(we), .i_mem_to_reg(sel),
        .i_write_register(wr), .i_result(res), .i_mem_read_data(mem), .i_pc_4(pc4),
        .i_imm_ext_out(imm), .i_read_register_1(rd1), .i_read_register_2(rd2),
        .o_read_data_1(rdata1_s), .o_read_data_2(rdata2_s), .o_write_data(wdata_s),
        .o_write_commit(commit_s), .o_commit_count(cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_wd();
        case (sel)
            2'b00: return res;
            2'b01: return mem;
            2'b10: return pc4;
            default: return imm;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (reset && we && wr != 5'd0 && wr == a) return model_wd();
        return model[a];
    endfunction

    // Advance one clock edge, updating the bench model with what the edge should commit.
    task automatic step();
        logic [31:0] wd;
        wd = model_wd();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model[28] = 32'h0000_1800;
            model[29] = 32'h0000_07FC;
            model_cnt = 32'd0;
        end else if (we && wr != 5'd0) begin
            model[wr] = wd;
            model_cnt = model_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic [4:0] a,
                         input logic [31:0] r, input logic [31:0] m,
                         input logic [31:0] p, input logic [31:0] i);
        we = w; sel = s; wr = a; res = r; mem = m; pc4 = p; imm = i;
    endtask

    task automatic test_reset();
        logic [31:0] want;
        drive(1'b1, 2'b00, 5'd3, 32'hAAAA_AAAA, 0, 0, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(1'b0, 2'b00, 5'd0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_count got %h want %h", cnt, 32'd0);
        end
        for (int a = 0; a < 32; a++) begin
            rd1 = 5'(a); rd2 = 5'(31 - a);
            #1;
            want = (a == 28) ? 32'h1800 : (a == 29) ? 32'h7FC : 32'd0;
            exp_q.push_back(want);
            want = (31 - a == 28) ? 32'h1800 : (31 - a == 29) ? 32'h7FC : 32'd0;
            exp_q.push_back(want);
            n_cmp++; e = exp_q.pop_front();
            if (rdata1 !== e) begin
                n_bad++; $display("FAIL reset_rd1[%0d] got %h want %h", a, rdata1, e);
            end
            n_cmp++; e = exp_q.pop_front();
            if (rdata2 !== e) begin
                n_bad++; $display("FAIL reset_rd2[%0d] got %h want %h", 31 - a, rdata2, e);
            end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF, 32'h1111, 32'h2222, 32'h3333);
        rd1 = 5'd5; rd2 = 5'd6;
        #1;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'd0);
        n_cmp++; e = exp_q.pop_front();
        if (rdata1 !== e) begin
            n_bad++; $display("FAIL bypass_rd1 got %h want %h", rdata1, e);
        end
        n_cmp++; e = exp_q.pop_front();
        if (rdata2 !== e) begin
            n_bad++; $display("FAIL bypass_rd2 got %h want %h", rdata2, e);
        end
        n_cmp++;
        if (commit !== 1'b1) begin
            n_bad++; $display("FAIL bypass_commit got %b want 1", commit);
        end
        step();
        we = 1'b0;
        #1;
        exp_q.push_back(32'hDEAD_BEEF);
        n_cmp++; e = exp_q.pop_front();
        if (rdata1 !== e) begin
            n_bad++; $display("FAIL stored_rd1 got %h want %h", rdata1, e);
        end
    endtask

    task automatic test_wb_mux();
        logic [31:0] c0;
        c0 = model_cnt;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 5'(8 + s), 32'd1, 32'd2, 32'd3, 32'd4);
            #1;
            exp_q.push_back(32'(s + 1));
            n_cmp++; e = exp_q.pop_front();
            if (wdata !== e) begin
                n_bad++; $display("FAIL mux_sel%0d got %h want %h", s, wdata, e);
            end
            step();
        end
        we = 1'b0;
        for (int a = 8; a < 12; a += 2) begin
            rd1 = 5'(a); rd2 = 5'(a + 1);
            #1;
            exp_q.push_back(32'(a - 7));
            exp_q.push_back(32'(a - 6));
            n_cmp++; e = exp_q.pop_front();
            if (rdata1 !== e) begin
                n_bad++; $display("FAIL mux_reg%0d got %h want %h", a, rdata1, e);
            end
            n_cmp++; e = exp_q.pop_front();
            if (rdata2 !== e) begin
                n_bad++; $display("FAIL mux_reg%0d got %h want %h", a + 1, rdata2, e);
            end
        end
        n_cmp++;
        if (cnt !== c0 + 32'd4) begin
            n_bad++; $display("FAIL mux_count got %h want %h", cnt, c0 + 32'd4);
        end
    endtask

    task automatic test_zero();
        logic [31:0] c0;
        c0 = model_cnt;
        drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
        rd1 = 5'd0; rd2 = 5'd0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_bad++; $display("FAIL zero_read got %h/%h want 0/0", rdata1, rdata2);
        end
        n_cmp++;
        if (commit !== 1'b0) begin
            n_bad++; $display("FAIL zero_commit got %b want 0", commit);
        end
        step();
        we = 1'b0;
        #1;
        n_cmp++;
        if (cnt !== c0 || rdata1 !== 32'd0) begin
            n_bad++; $display("FAIL zero_after got cnt %h rd %h want cnt %h rd 0", cnt, rdata1, c0);
        end
    endtask

    task automatic test_reset_drop();
        drive(1'b1, 2'b00, 5'd7, 32'h0000_0055, 0, 0, 0);
        step();
        reset = 1'b0;
        drive(1'b1, 2'b00, 5'd7, 32'h0000_1234, 0, 0, 0);
        rd1 = 5'd7; rd2 = 5'd29;
        #1;
        exp_q.push_back(model_rd(5'd7));
        n_cmp++; e = exp_q.pop_front();
        if (rdata1 !== e || commit !== 1'b0) begin
            n_bad++; $display("FAIL rst_nobypass got %h c%b want %h c0", rdata1, commit, e);
        end
        step();
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0 || cnt !== 32'd0) begin
            n_bad++; $display("FAIL rst_drop got %h cnt %h want 0 cnt 0", rdata1, cnt);
        end
        reset = 1'b1;
        step();
        we = 1'b0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h1234 || cnt !== 32'd1) begin
            n_bad++; $display("FAIL rst_release got %h cnt %h want 1234 cnt 1", rdata1, cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] prev;
        prev = 5'd1;
        for (int a = 1; a < 32; a++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 5'(a), $urandom, $urandom, $urandom, $urandom);
            rd1 = prev; rd2 = 5'(a);
            #1;
            exp_q.push_back(model_rd(rd1));
            exp_q.push_back(model_rd(rd2));
            n_cmp++; e = exp_q.pop_front();
            if (rdata1 !== e) begin
                n_bad++; $display("FAIL b2b_rd1[%0d] got %h want %h", rd1, rdata1, e);
            end
            n_cmp++; e = exp_q.pop_front();
            if (rdata2 !== e) begin
                n_bad++; $display("FAIL b2b_rd2[%0d] got %h want %h", rd2, rdata2, e);
            end
            step();
            prev = 5'(a);
        end
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd1 = 5'(a); rd2 = 5'(a ^ 5'h1F);
            #1;
            exp_q.push_back(model_rd(rd1));
            exp_q.push_back(model_rd(rd2));
            n_cmp++; e = exp_q.pop_front();
            if (rdata1 !== e) begin
                n_bad++; $display("FAIL b2b_final1[%0d] got %h want %h", a, rdata1, e);
            end
            n_cmp++; e = exp_q.pop_front();
            if (rdata2 !== e) begin
                n_bad++; $display("FAIL b2b_final2[%0d] got %h want %h", rd2, rdata2, e);
            end
        end
        n_cmp++;
        if (cnt !== model_cnt) begin
            n_bad++; $display("FAIL b2b_count got %h want %h", cnt, model_cnt);
        end
    endtask

    task automatic test_wrap();
        int guard;
        n_cmp++;
        if (cnt_s !== model_cnt[2:0]) begin
            n_bad++; $display("FAIL wrap_track got %h want %h", cnt_s, model_cnt[2:0]);
        end
        guard = 0;
        drive(1'b1, 2'b11, 5'd12, 0, 0, 0, 32'hCAFE_0000);
        while (model_cnt[2:0] != 3'd7 && guard < 16) begin
            step();
            guard++;
        end
        #1;
        n_cmp++;
        if (cnt_s !== 3'd7) begin
            n_bad++; $display("FAIL wrap_max got %h want 7", cnt_s);
        end
        step();
        we = 1'b0;
        #1;
        n_cmp++;
        if (cnt_s !== 3'd0 || cnt !== model_cnt) begin
            n_bad++; $display("FAIL wrap_zero got %h/%h want 0/%h", cnt_s, cnt, model_cnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        rd1 = 5'd0; rd2 = 5'd0;
        drive(1'b0, 2'b00, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model_cnt = 32'd0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_wb_mux();
        test_zero();
        test_reset_drop();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing tests");
        $fatal(1, "timeout");
    end

endmodule
